// File: rtl/micro_sequencer.sv
// Micro-program sequencer: dispatches macro opcodes into control-store routines.
// Optional retire watchdog enabled by defining USEQ_WATCHDOG_EN.
module micro_sequencer #(
  parameter int MINST_WIDTH = 44,
  parameter int UPC_WIDTH   = 8,
  parameter int WDOG_LIMIT  = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   instr_valid,
  input  logic [31:0]            instr_in,
  output logic                   instr_ready,
  output logic [31:0]            instr_q,
  output logic                   cs_rd_en,
  output logic [UPC_WIDTH-1:0]   cs_addr,
  input  logic [MINST_WIDTH-1:0] cs_data,
  input  logic                   alu_flag_z,
  input  logic                   dp_stall,
  output logic [MINST_WIDTH-1:0] minstr_out,
  output logic                   minstr_valid,
  output logic                   seq_busy,
  output logic                   seq_done,
  output logic                   wdog_err
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    LOAD,
    ISSUE
  } state_t;

  state_t                 state_q, state_d;
  logic [UPC_WIDTH-1:0]   upc_q, upc_d;
  logic [MINST_WIDTH-1:0] mir_q, mir_d;
  logic [31:0]            ir_q, ir_d;
  logic                   done_q, done_d;

  logic [2:0]           br_t;
  logic [UPC_WIDTH-1:0] br_tgt;
  logic                 is_end;
  logic                 retire;

  assign br_t   = mir_q[MINST_WIDTH-1 -: 3];
  assign br_tgt = mir_q[10 +: UPC_WIDTH];
  assign is_end = (br_t == 3'b111);

`ifdef USEQ_WATCHDOG_EN
  localparam int WCW = $clog2(WDOG_LIMIT + 1);
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic           werr_q, werr_d;
`endif

  always_comb begin
    state_d = state_q;
    upc_d   = upc_q;
    mir_d   = mir_q;
    ir_d    = ir_q;
    done_d  = 1'b0;
    retire  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (instr_valid) begin
          ir_d    = instr_in;
          upc_d   = UPC_WIDTH'({instr_in[31:27], 3'b000});
          state_d = FETCH;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        mir_d   = cs_data;
        state_d = ISSUE;
      end
      ISSUE: begin
        if (!dp_stall) begin
          retire  = 1'b1;
          state_d = FETCH;
          unique case (1'b1)
            (br_t == 3'b100): upc_d = br_tgt;
            (br_t == 3'b011): upc_d = alu_flag_z ? br_tgt : upc_q + 1'b1;
            is_end: begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
            default: upc_d = upc_q + 1'b1;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef USEQ_WATCHDOG_EN
    wcnt_d = wcnt_q;
    werr_d = werr_q;
    if (state_q == IDLE && instr_valid) wcnt_d = '0;
    // Runaway routine: abort on the limit-th retire unless it is the end.
    if (retire && !is_end) begin
      wcnt_d = wcnt_q + 1'b1;
      if (wcnt_q == WCW'(WDOG_LIMIT - 1)) begin
        state_d = IDLE;
        werr_d  = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      upc_q   <= '0;
      mir_q   <= '0;
      ir_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      mir_q   <= mir_d;
      ir_q    <= ir_d;
      done_q  <= done_d;
    end
  end

`ifdef USEQ_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q <= '0;
      werr_q <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      werr_q <= werr_d;
    end
  end
  assign wdog_err = werr_q;
`else
  assign wdog_err = 1'b0;
`endif

  assign instr_ready  = (state_q == IDLE);
  assign instr_q      = ir_q;
  assign cs_rd_en     = (state_q == FETCH);
  assign cs_addr      = upc_q;
  assign minstr_out   = mir_q;
  assign minstr_valid = (state_q == ISSUE);
  assign seq_busy     = (state_q != IDLE);
  assign seq_done     = done_q;

endmodule
